// File: rtl/key_button_debounce_encoder.sv
// Synchronises and debounces N_KEYS raw button lines, then encodes a single held key to a
// 1-based value with press/release strobes, multi-key rejection and optional auto-repeat.
module key_button_debounce_encoder #(
  parameter int unsigned N_KEYS          = 11,
  parameter int unsigned VAL_W           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 10000,
  parameter int unsigned CNT_W           = 14,
  parameter int unsigned REPEAT_EN       = 0,
  parameter int unsigned REPEAT_DELAY    = 5000,
  parameter int unsigned REPEAT_PERIOD   = 2000
) (
  input  logic              clk_1mhz,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] key_button_in,
  output logic              button_pressed,
  output logic [VAL_W-1:0]  button_value,
  output logic              press_pulse,
  output logic              release_pulse,
  output logic              multi_key
);

  localparam logic [CNT_W-1:0]  DbMax  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  RepDly = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0]  RepPer = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [N_KEYS-1:0] KeyOne = N_KEYS'(1);

  typedef enum logic [1:0] {StIdle, StHeld, StMulti} state_e;

  logic [N_KEYS-1:0] r_sync1, r_sync2, r_cand, r_stable;
  logic [CNT_W-1:0]  r_dcnt, r_rcnt;
  logic              r_rep_phase;
  state_e            r_state;
  logic              r_pressed, r_press, r_release, r_multi;
  logic [VAL_W-1:0]  r_value;

  logic [N_KEYS-1:0] w_cand_d, w_stable_d;
  logic [CNT_W-1:0]  w_dcnt_d, w_rcnt_d, w_rep_lim;
  logic              w_rep_phase_d;
  state_e            w_state_d;
  logic              w_pressed_d, w_press_d, w_release_d, w_multi_d;
  logic [VAL_W-1:0]  w_value_d, w_idx;
  logic              w_none, w_multi;

  always_comb begin
    w_cand_d = r_cand;
    w_dcnt_d = r_dcnt;
    if (r_sync2 != r_cand) begin
      w_cand_d = r_sync2;
      w_dcnt_d = '0;
    end else if (r_dcnt != DbMax) begin
      w_dcnt_d = r_dcnt + 1'b1;
    end
    w_stable_d = ((r_dcnt == DbMax) && (r_cand != r_stable)) ? r_cand : r_stable;
  end

  // The FSM decodes the next stable value so outputs land on the same edge stable updates.
  always_comb begin
    w_none  = (w_stable_d == '0);
    w_multi = |(w_stable_d & (w_stable_d - KeyOne));
    w_idx   = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      if (w_stable_d[i]) w_idx = VAL_W'(i + 1);
    end
  end

  assign w_rep_lim = r_rep_phase ? RepPer : RepDly;

  always_comb begin
    w_state_d     = r_state;
    w_pressed_d   = r_pressed;
    w_value_d     = r_value;
    w_multi_d     = r_multi;
    w_press_d     = 1'b0;
    w_release_d   = 1'b0;
    w_rcnt_d      = r_rcnt;
    w_rep_phase_d = r_rep_phase;
    unique case (r_state)
      StIdle: begin
        if (w_multi) begin
          w_state_d = StMulti;
          w_multi_d = 1'b1;
        end else if (!w_none) begin
          w_state_d     = StHeld;
          w_press_d     = 1'b1;
          w_pressed_d   = 1'b1;
          w_value_d     = w_idx;
          w_rcnt_d      = '0;
          w_rep_phase_d = 1'b0;
        end
      end
      StHeld: begin
        if (w_none) begin
          w_state_d   = StIdle;
          w_release_d = 1'b1;
          w_pressed_d = 1'b0;
          w_value_d   = '0;
        end else if (w_multi) begin
          w_state_d   = StMulti;
          w_release_d = 1'b1;
          w_pressed_d = 1'b0;
          w_value_d   = '0;
          w_multi_d   = 1'b1;
        end else if (w_idx != r_value) begin
          w_release_d   = 1'b1;
          w_press_d     = 1'b1;
          w_value_d     = w_idx;
          w_rcnt_d      = '0;
          w_rep_phase_d = 1'b0;
        end else if (REPEAT_EN != 0) begin
          // First repeat after REPEAT_DELAY, then every REPEAT_PERIOD; counter reloads on hit.
          if (r_rcnt == w_rep_lim) begin
            w_press_d     = 1'b1;
            w_rcnt_d      = '0;
            w_rep_phase_d = 1'b1;
          end else begin
            w_rcnt_d = r_rcnt + 1'b1;
          end
        end
      end
      StMulti: begin
        if (w_none) begin
          w_state_d = StIdle;
          w_multi_d = 1'b0;
        end
      end
      default: begin
        w_state_d   = StIdle;
        w_pressed_d = 1'b0;
        w_value_d   = '0;
        w_multi_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_1mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1     <= '0;
      r_sync2     <= '0;
      r_cand      <= '0;
      r_stable    <= '0;
      r_dcnt      <= '0;
      r_rcnt      <= '0;
      r_rep_phase <= 1'b0;
      r_state     <= StIdle;
      r_pressed   <= 1'b0;
      r_value     <= '0;
      r_press     <= 1'b0;
      r_release   <= 1'b0;
      r_multi     <= 1'b0;
    end else begin
      r_sync1     <= key_button_in;
      r_sync2     <= r_sync1;
      r_cand      <= w_cand_d;
      r_stable    <= w_stable_d;
      r_dcnt      <= w_dcnt_d;
      r_rcnt      <= w_rcnt_d;
      r_rep_phase <= w_rep_phase_d;
      r_state     <= w_state_d;
      r_pressed   <= w_pressed_d;
      r_value     <= w_value_d;
      r_press     <= w_press_d;
      r_release   <= w_release_d;
      r_multi     <= w_multi_d;
    end
  end

  assign button_pressed = r_pressed;
  assign button_value   = r_value;
  assign press_pulse    = r_press;
  assign release_pulse  = r_release;
  assign multi_key      = r_multi;

endmodule

// File: tb/tb_key_button_debounce_encoder.sv
// Directed bench: one encoder without auto-repeat, one with, sharing clock, reset and keys.
module tb_key_button_debounce_encoder;

  localparam int unsigned NKeys = 11;
  localparam int unsigned ValW  = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [NKeys-1:0] keys = '0;

  logic             pr0, pp0, rp0, mk0;
  logic [ValW-1:0]  val0;
  logic             pr1, pp1, rp1, mk1;
  logic [ValW-1:0]  val1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  key_button_debounce_encoder #(
    .N_KEYS(NKeys), .VAL_W(ValW), .DEBOUNCE_CYCLES(4), .CNT_W(4),
    .REPEAT_EN(0), .REPEAT_DELAY(6), .REPEAT_PERIOD(3)
  ) u_dut0 (
    .clk_1mhz(clk), .rst_n(rst_n), .key_button_in(keys),
    .button_pressed(pr0), .button_value(val0), .press_pulse(pp0),
    .release_pulse(rp0), .multi_key(mk0)
  );

  key_button_debounce_encoder #(
    .N_KEYS(NKeys), .VAL_W(ValW), .DEBOUNCE_CYCLES(4), .CNT_W(4),
    .REPEAT_EN(1), .REPEAT_DELAY(6), .REPEAT_PERIOD(3)
  ) u_dut1 (
    .clk_1mhz(clk), .rst_n(rst_n), .key_button_in(keys),
    .button_pressed(pr1), .button_value(val1), .press_pulse(pp1),
    .release_pulse(rp1), .multi_key(mk1)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_out0(input string tag, input int pr, input int v, input int pp,
                            input int rp, input int mk);
    check({tag, ".pressed"}, int'(pr0), pr);
    check({tag, ".value"}, int'(val0), v);
    check({tag, ".press"}, int'(pp0), pp);
    check({tag, ".release"}, int'(rp0), rp);
    check({tag, ".multi"}, int'(mk0), mk);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int pulses;
    int exp_pp;

    // Reset state, with key bit 2 already held.
    keys = NKeys'(1) << 2;
    #12;
    check_out0("reset", 0, 0, 0, 0, 0);
    check("reset.dut1_value", int'(val1), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single press: outputs change exactly 7 clocks after the input edge.
    tick(6);
    check_out0("press3_early", 0, 0, 0, 0, 0);
    tick(1);
    check_out0("press3", 1, 3, 1, 0, 0);
    tick(1);
    check_out0("press3_hold", 1, 3, 0, 0, 0);
    keys = '0;
    tick(6);
    check_out0("rel3_early", 1, 3, 0, 0, 0);
    tick(1);
    check_out0("rel3", 0, 0, 0, 1, 0);
    tick(1);
    check_out0("rel3_after", 0, 0, 0, 0, 0);

    // Bounce on bit 0: 2-cycle levels never reach stable.
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      keys[0] = (i % 2 == 0);
      for (int j = 0; j < 2; j++) begin
        tick(1);
        pulses += int'(pp0) + int'(rp0) + int'(pr0);
      end
    end
    check("bounce_quiet", pulses, 0);
    keys[0] = 1'b1;
    tick(6);
    check("bounce_early_press", int'(pp0), 0);
    tick(1);
    check_out0("bounce_press", 1, 1, 1, 0, 0);
    keys = '0;
    tick(7);
    check_out0("bounce_rel", 0, 0, 0, 1, 0);

    // Multi-key rejection.
    keys = NKeys'(1) << 10;
    tick(7);
    check_out0("k11_press", 1, 11, 1, 0, 0);
    keys = keys | (NKeys'(1) << 4);
    tick(7);
    check_out0("multi_enter", 0, 0, 0, 1, 1);
    keys = NKeys'(1) << 4;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      pulses += int'(pp0) + int'(rp0) + int'(pr0);
    end
    check("ghost_no_press", pulses, 0);
    check("ghost_multi", int'(mk0), 1);
    keys = '0;
    tick(6);
    check("multi_hold", int'(mk0), 1);
    tick(1);
    check_out0("multi_exit", 0, 0, 0, 0, 0);

    // Direct switch bit 1 -> bit 7.
    keys = NKeys'(1) << 1;
    tick(7);
    check_out0("k2_press", 1, 2, 1, 0, 0);
    keys = NKeys'(1) << 7;
    tick(6);
    check("switch_early_value", int'(val0), 2);
    tick(1);
    check_out0("switch", 1, 8, 1, 1, 0);
    keys = '0;
    tick(7);
    check_out0("k8_rel", 0, 0, 0, 1, 0);

    // Auto-repeat on bit 5 (dut1), none on dut0.
    keys = NKeys'(1) << 5;
    tick(7);
    check("rep_press", int'(pp1), 1);
    check("rep_press_dut0", int'(pp0), 1);
    for (int k = 1; k <= 20; k++) begin
      tick(1);
      exp_pp = (k == 6 || k == 9 || k == 12 || k == 15 || k == 18) ? 1 : 0;
      check($sformatf("rep_pulse_%0d", k), int'(pp1), exp_pp);
      check($sformatf("rep_value_%0d", k), int'(val1), 6);
      check($sformatf("norep_dut0_%0d", k), int'(pp0), 0);
    end
    keys = '0;
    tick(7);
    check("rep_rel_dut1", int'(rp1), 1);
    check_out0("rep_rel_dut0", 0, 0, 0, 1, 0);

    // Asynchronous reset while bit 3 is held.
    keys = NKeys'(1) << 3;
    tick(7);
    check_out0("k4_press", 1, 4, 1, 0, 0);
    tick(2);
    rst_n = 1'b0;
    #1;
    check_out0("async_reset", 0, 0, 0, 0, 0);
    tick(1);
    rst_n = 1'b1;
    tick(6);
    check_out0("post_reset_early", 0, 0, 0, 0, 0);
    tick(1);
    check_out0("post_reset_press", 1, 4, 1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
